// File: rtl/seg7_scan_counter.sv
// seg7_scan_counter: prescaled up/down BCD counter with a time-multiplexed
// seven-segment display driver (one digit lit at a time, registered outputs).
// Optional feature: define SEG7_LZ_BLANK_EN to blank leading-zero digits
// (digit 0 is never blanked). Default build shows every digit's glyph.
module seg7_scan_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 100,
  parameter int SCAN_DIV   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    wrap,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel
);

  // Counter widths are clamped to 1 so divide-by-1 and single-digit builds stay legal
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [7:0]    GLYPH_ZERO = 8'b1111_1100;

  logic [PW-1:0]           presc_q, presc_d;
  logic [SW-1:0]           scan_q, scan_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] count_q, count_d;
  logic                    wrap_q, wrap_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_sel_q, dig_sel_d;

  logic                    tick;
  logic                    scan_adv;
  logic [NUM_DIGITS:0]     carry_c;
  logic [3:0]              digit_q [NUM_DIGITS];

  // Segment pattern {a,b,c,d,e,f,g,dp}; non-BCD codes go dark
  function automatic logic [7:0] glyph(input logic [3:0] v);
    case (v)
      4'd0:    glyph = 8'b1111_1100;
      4'd1:    glyph = 8'b0110_0000;
      4'd2:    glyph = 8'b1101_1010;
      4'd3:    glyph = 8'b1111_0010;
      4'd4:    glyph = 8'b0110_0110;
      4'd5:    glyph = 8'b1011_0110;
      4'd6:    glyph = 8'b1011_1110;
      4'd7:    glyph = 8'b1110_0000;
      4'd8:    glyph = 8'b1111_1110;
      4'd9:    glyph = 8'b1110_0110;
      default: glyph = 8'b0000_0000;
    endcase
  endfunction

  // Unpack the count into per-digit nibbles
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_q[gi] = count_q[4*gi +: 4];
    end
  endgenerate

  // Prescaler: free-runs only while enabled, tick on its last state
  always_comb begin
    tick    = en && (presc_q == PRESC_LAST);
    presc_d = presc_q;
    if (en) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
  end

  // BCD ripple: carry/borrow walks up through the digits in one cycle
  always_comb begin
    count_d    = count_q;
    carry_c    = '0;
    carry_c[0] = tick;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (carry_c[k]) begin
        if (up) begin
          if (digit_q[k] >= 4'd9) begin
            count_d[4*k +: 4] = 4'd0;
            carry_c[k+1]      = 1'b1;
          end else begin
            count_d[4*k +: 4] = digit_q[k] + 4'd1;
          end
        end else begin
          if (digit_q[k] == 4'd0) begin
            count_d[4*k +: 4] = 4'd9;
            carry_c[k+1]      = 1'b1;
          end else if (digit_q[k] > 4'd9) begin
            count_d[4*k +: 4] = 4'd9;
          end else begin
            count_d[4*k +: 4] = digit_q[k] - 4'd1;
          end
        end
      end
    end
    wrap_d = carry_c[NUM_DIGITS];
  end

  // Scan divider and digit index rotate regardless of en
  always_comb begin
    scan_adv = (scan_q == SCAN_LAST);
    scan_d   = scan_adv ? '0 : scan_q + 1'b1;
    idx_d    = idx_q;
    if (scan_adv) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lead_zero;

  // lead_zero[k]: digit k and everything above it are zero
  always_comb begin
    lead_zero[NUM_DIGITS-1] = (digit_q[NUM_DIGITS-1] == 4'd0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      lead_zero[k] = lead_zero[k+1] && (digit_q[k] == 4'd0);
    end
  end

  // Display decode with leading-zero blanking (digit 0 always shown)
  always_comb begin
    seg_d = glyph(digit_q[idx_q]);
    if ((idx_q != '0) && lead_zero[idx_q]) begin
      seg_d = 8'b0000_0000;
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      dig_sel_d[k] = (idx_q == IW'(k));
    end
  end
`else
  // Display decode: glyph of the currently indexed digit, one-hot select
  always_comb begin
    seg_d = glyph(digit_q[idx_q]);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      dig_sel_d[k] = (idx_q == IW'(k));
    end
  end
`endif

  // State registers; reset overrides any pending tick, scan step or wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      scan_q    <= '0;
      idx_q     <= '0;
      count_q   <= '0;
      wrap_q    <= 1'b0;
      seg_q     <= GLYPH_ZERO;
      dig_sel_q <= NUM_DIGITS'(1);
    end else begin
      presc_q   <= presc_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      seg_q     <= seg_d;
      dig_sel_q <= dig_sel_d;
    end
  end

  assign count_bcd = count_q;
  assign wrap      = wrap_q;
  assign seg       = seg_q;
  assign dig_sel   = dig_sel_q;

endmodule

// File: doc/seg7_scan_counter.md
SEG7_SCAN_COUNTER -- requirements
Module: seg7_scan_counter

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of BCD digits, legal range 1..8.
REQ-002 The block SHALL have parameter TICK_DIV, default 100, giving clk cycles per count step, legal range >= 1.
REQ-003 The block SHALL have parameter SCAN_DIV, default 16, giving clk cycles per display digit slot, legal range >= 1.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 en  input  1  count enable; 0 freezes the prescaler and the count, while scanning continues.
REQ-007 up  input  1  direction; 1 counts up, 0 counts down; sampled at each tick.
REQ-008 count_bcd  output  4*NUM_DIGITS  current count; digit k occupies bits [4k+3:4k], digit 0 is least significant.
REQ-009 wrap  output  1  one-cycle pulse on rollover (up: all-9 to all-0; down: all-0 to all-9).
REQ-010 seg  output  8  segment pattern {a,b,c,d,e,f,g,dp}, MSB = a, active-high, dp always 0.
REQ-011 dig_sel  output  NUM_DIGITS  one-hot, active-high digit enable aligned with seg.

Function
REQ-012 The prescaler SHALL count 0..TICK_DIV-1 while en=1, hold while en=0, and assert an internal tick on the cycle it equals TICK_DIV-1 with en=1, then return to 0.
REQ-013 With TICK_DIV=1, a tick SHALL occur on every cycle with en=1.
REQ-014 On a tick with up=1, digit 0 SHALL increment; a digit at 9 SHALL become 0 and carry into the next digit, all within the same cycle.
REQ-015 On a tick with up=0, digit 0 SHALL decrement; a digit at 0 SHALL become 9 and borrow from the next digit, all within the same cycle.
REQ-016 wrap SHALL be 1 for exactly the cycle after a tick whose carry or borrow leaves the most significant digit, and 0 otherwise.
REQ-017 count_bcd SHALL change only on the cycle after a tick, and every digit SHALL always hold a value in 0..9.
REQ-018 The scan divider SHALL count 0..SCAN_DIV-1 independently of en; at SCAN_DIV-1 the digit index SHALL advance by 1, wrapping from NUM_DIGITS-1 to 0.
REQ-019 seg and dig_sel SHALL be registered and SHALL present the glyph of the indexed digit's current value one cycle after the index or the value changes.
REQ-020 Glyphs 0..9 SHALL be 11111100, 01100000, 11011010, 11110010, 01100110, 10110110, 10111110, 11100000, 11111110, 11100110.
REQ-021 A digit value outside 0..9 (unreachable) SHALL decode to 00000000.
REQ-022 dig_sel SHALL always be exactly one-hot, including when NUM_DIGITS=1, where it is constant 1.
REQ-023 A direction change between ticks SHALL take effect at the next tick, with no extra step.

Reset
REQ-024 While rst=1 at a clk edge: prescaler, scan divider, digit index and count_bcd SHALL become 0, wrap 0, dig_sel SHALL select digit 0, and seg SHALL be 11111100.
REQ-025 rst SHALL take priority over en and any pending tick, scan advance or wrap.
REQ-026 Counting SHALL resume from zero, with a full TICK_DIV interval, on the first cycle after rst deasserts.

Configuration
REQ-027 With macro SEG7_LZ_BLANK_EN defined, a digit SHALL output seg 00000000 when it and all more significant digits are 0, except digit 0, which is never blanked; dig_sel SHALL be unaffected.
REQ-028 Without SEG7_LZ_BLANK_EN, every digit SHALL show its glyph, including leading zeros.

Verification
REQ-029 NUM_DIGITS=2, TICK_DIV=1, up=1, en=1 from reset -> count_bcd 0x00, 0x01 ... 0x99, then 0x00 with wrap=1 for one cycle, 100 cycles after the first tick.
REQ-030 up=0 from reset, TICK_DIV=1 -> first tick gives count_bcd all-9 (0x99 for 2 digits) with a wrap pulse; next tick gives 0x98.
REQ-031 TICK_DIV=4; drop en for 3 cycles mid-interval -> tick delayed by exactly 3 cycles and count held; dig_sel keeps rotating.
REQ-032 NUM_DIGITS=4, SCAN_DIV=2, count 0x0507 -> dig_sel 0001/0010/0100/1000, each for 2 cycles, with seg 10110110 on dig_sel 0100 and 11111100 on dig_sel 1000; with SEG7_LZ_BLANK_EN, seg on dig_sel 1000 is 00000000.
REQ-033 Assert rst mid-count while wrap would pulse -> next cycle count 0, wrap 0, dig_sel 0001, seg 11111100.
